// File: rtl/booth_multiplier_if.sv
// rtl/booth_multiplier_if.sv - multiply handshake between EX (master) and the Booth multiplier (slave)
interface booth_multiplier_if #(parameter int XLEN = 32);
    logic                mult_start_i;
    logic                mult_signed_i;
    logic [XLEN-1:0]     mult_opd1_i;
    logic [XLEN-1:0]     mult_opd2_i;
    logic                mult_ack_i;
    logic                mult_flush_i;
    logic [2*XLEN-1:0]   product_o;
    logic                mult_end_o;
    logic                mult_busy_o;

    modport master (
        output mult_start_i, mult_signed_i, mult_opd1_i, mult_opd2_i, mult_ack_i, mult_flush_i,
        input  product_o, mult_end_o, mult_busy_o
    );

    modport slave (
        input  mult_start_i, mult_signed_i, mult_opd1_i, mult_opd2_i, mult_ack_i, mult_flush_i,
        output product_o, mult_end_o, mult_busy_o
    );
endinterface

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - iterative radix-4 Booth multiplier, one digit per cycle
module booth_multiplier #(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    booth_multiplier_if.slave   mul_if
);
    localparam int W    = XLEN + 2;
    localparam int AW   = 2 * W;
    localparam int ITER = (XLEN + 2) / 2;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [W-1:0]        a_q, a_d;
    logic [W:0]          b_q, b_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*XLEN-1:0]   product_q, product_d;
    logic                end_q, end_d;

    logic [W-1:0]        a_ext, b_ext, addend, upper;
    logic [AW-1:0]       acc_sum, acc_shift;

    always_comb begin
        a_ext = {{2{mul_if.mult_signed_i & mul_if.mult_opd1_i[XLEN-1]}}, mul_if.mult_opd1_i};
        b_ext = {{2{mul_if.mult_signed_i & mul_if.mult_opd2_i[XLEN-1]}}, mul_if.mult_opd2_i};

        case (b_q[2:0])
            3'b001, 3'b010: addend = a_q;
            3'b011:         addend = {a_q[W-2:0], 1'b0};
            3'b100:         addend = ~{a_q[W-2:0], 1'b0} + W'(1);
            3'b101, 3'b110: addend = ~a_q + W'(1);
            default:        addend = '0;
        endcase

        // Digits land in the upper half; the shift walks them down to weight 4^i.
        upper     = acc_q[AW-1:W] + addend;
        acc_sum   = {upper, acc_q[W-1:0]};
        acc_shift = $signed(acc_sum) >>> 2;

        state_d   = state_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        count_d   = count_q;
        product_d = product_q;
        end_d     = end_q;

        if (mul_if.mult_flush_i) begin
            state_d = IDLE;
            end_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_if.mult_start_i) begin
                        a_d     = a_ext;
                        b_d     = {b_ext, 1'b0};
                        acc_d   = '0;
                        count_d = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (!mul_if.mult_start_i) begin
                        state_d = IDLE;
                    end else begin
                        acc_d   = acc_shift;
                        b_d     = {{2{b_q[W]}}, b_q[W:2]};
                        count_d = count_q + CW'(1);
                        if (count_q == CW'(ITER - 1)) begin
                            product_d = acc_shift[2*XLEN-1:0];
                            end_d     = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                DONE: begin
                    if (mul_if.mult_ack_i || !mul_if.mult_start_i) begin
                        end_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    end_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            count_q   <= count_d;
            product_q <= product_d;
            end_q     <= end_d;
        end
    end

    assign mul_if.product_o   = product_q;
    assign mul_if.mult_end_o  = end_q;
    assign mul_if.mult_busy_o = (state_q == BUSY);
endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier against an arithmetic model
module tb_booth_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    booth_multiplier_if #(.XLEN(32)) mif ();
    booth_multiplier #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .mul_if(mif));

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (mif.mult_end_o === 1'b1) break;
        end
        if (mif.mult_end_o !== 1'b1) cyc = 99;
    endtask

    task automatic run_op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        mif.mult_signed_i = s;
        mif.mult_opd1_i   = a;
        mif.mult_opd2_i   = b;
        mif.mult_start_i  = 1'b1;
        wait_end(cyc);
        chk({tag, "_lat"}, 64'(cyc), 64'd18);
        chk({tag, "_prod"}, mif.product_o, ref_mul(s, a, b));
        mif.mult_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.mult_ack_i   = 1'b0;
        mif.mult_start_i = 1'b0;
        chk({tag, "_endlow"}, 64'(mif.mult_end_o), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [63:0] held;
        logic [31:0] ra, rb;
        bit stable, seen_end;

        mif.mult_start_i  = 1'b0;
        mif.mult_signed_i = 1'b0;
        mif.mult_opd1_i   = '0;
        mif.mult_opd2_i   = '0;
        mif.mult_ack_i    = 1'b0;
        mif.mult_flush_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_prod", mif.product_o, 64'd0);
        chk("rst_end", 64'(mif.mult_end_o), 64'd0);
        chk("rst_busy", 64'(mif.mult_busy_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 3 x 5 with busy check one cycle after acceptance
        mif.mult_opd1_i  = 32'd3;
        mif.mult_opd2_i  = 32'd5;
        mif.mult_start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_accept", 64'(mif.mult_busy_o), 64'd1);
        wait_end(cyc);
        chk("u3x5_lat", 64'(cyc + 1), 64'd18);
        chk("u3x5_prod", mif.product_o, 64'h0000_0000_0000_000F);
        chk("u3x5_busy_done", 64'(mif.mult_busy_o), 64'd0);
        mif.mult_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.mult_ack_i   = 1'b0;
        mif.mult_start_i = 1'b0;
        chk("u3x5_endlow", 64'(mif.mult_end_o), 64'd0);
        @(negedge clk);

        run_op("s_m2x3", 1'b1, 32'hFFFF_FFFE, 32'd3);
        chk("s_m2x3_const", mif.product_o, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000);
        chk("s_min_sq_const", mif.product_o, 64'h4000_0000_0000_0000);
        run_op("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("s_m1xm1_const", mif.product_o, 64'h0000_0000_0000_0001);
        run_op("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("u_max_sq_const", mif.product_o, 64'hFFFF_FFFE_0000_0001);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra[31] = 1'b1;
            run_op($sformatf("rnd%0d", i), bit'($urandom_range(0, 1)), ra, rb);
        end

        // Stall in DONE with changing operands, then back-to-back 7 x 6
        mif.mult_signed_i = 1'b0;
        mif.mult_opd1_i   = 32'd1000;
        mif.mult_opd2_i   = 32'd1000;
        mif.mult_start_i  = 1'b1;
        wait_end(cyc);
        chk("stall_lat", 64'(cyc), 64'd18);
        held = mif.product_o;
        chk("stall_prod", held, 64'd1000000);
        mif.mult_opd1_i = 32'd7;
        mif.mult_opd2_i = 32'd6;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mif.mult_end_o !== 1'b1 || mif.product_o !== held) stable = 1'b0;
        end
        chk("stall_stable", 64'(stable), 64'd1);
        mif.mult_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.mult_ack_i = 1'b0;
        chk("stall_ack_end", 64'(mif.mult_end_o), 64'd0);
        chk("stall_ack_busy", 64'(mif.mult_busy_o), 64'd0);
        wait_end(cyc);
        chk("b2b_lat", 64'(cyc), 64'd18);
        chk("b2b_prod", mif.product_o, 64'd42);
        mif.mult_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.mult_ack_i   = 1'b0;
        mif.mult_start_i = 1'b0;
        @(negedge clk);

        // Flush at BUSY cycle 9
        mif.mult_signed_i = 1'b1;
        mif.mult_opd1_i   = 32'd123;
        mif.mult_opd2_i   = 32'hFFFF_FF00;
        mif.mult_start_i  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("flush_pre_busy", 64'(mif.mult_busy_o), 64'd1);
        mif.mult_flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.mult_flush_i = 1'b0;
        mif.mult_start_i = 1'b0;
        chk("flush_busy", 64'(mif.mult_busy_o), 64'd0);
        chk("flush_end", 64'(mif.mult_end_o), 64'd0);
        chk("flush_prod_kept", mif.product_o, 64'd42);
        seen_end = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mif.mult_end_o !== 1'b0) seen_end = 1'b1;
        end
        chk("flush_no_end", 64'(seen_end), 64'd0);
        run_op("post_flush", 1'b1, 32'd123, 32'hFFFF_FF00);

        // Asynchronous reset between clock edges mid-BUSY
        mif.mult_signed_i = 1'b0;
        mif.mult_opd1_i   = 32'hDEAD_BEEF;
        mif.mult_opd2_i   = 32'h1234_5678;
        mif.mult_start_i  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_prod", mif.product_o, 64'd0);
        chk("arst_end", 64'(mif.mult_end_o), 64'd0);
        chk("arst_busy", 64'(mif.mult_busy_o), 64'd0);
        mif.mult_start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen_end = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mif.mult_end_o !== 1'b0 || mif.mult_busy_o !== 1'b0) seen_end = 1'b1;
        end
        chk("arst_idle", 64'(seen_end), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
